data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL provide parameter DEPTH, default 256: number of 32-bit words; power of two.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 2: wait states inserted before each access, range 0-15.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port req_valid, input, 1 bit: the processor side presents a request.
REQ-006 SHALL provide port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-007 SHALL provide port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL provide port req_addr, input, 32 bits: byte address from the ALU result.
REQ-009 SHALL provide port req_wdata, input, 32 bits: store data from the register file second read port.
REQ-010 SHALL provide port resp_valid, output, 1 bit: a response is held.
REQ-011 SHALL provide port resp_ready, input, 1 bit: the requester takes the response.
REQ-012 SHALL provide port resp_rdata, output, 32 bits: load data; 0 for stores.
REQ-013 SHALL provide port resp_err, output, 1 bit: the request faulted (see REQ-024).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACCESS and RESP.
REQ-015 SHALL drive req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with req_valid && req_ready, latching write, addr and wdata; later input changes SHALL be ignored.
REQ-017 On accept, SHALL load the wait counter with WAIT_CYCLES-1 and go to WAIT; if WAIT_CYCLES = 0 it SHALL go directly to ACCESS.
REQ-018 In WAIT, SHALL decrement the counter each edge and go to ACCESS on the edge where the counter is 0.
REQ-019 In ACCESS, for exactly one cycle, SHALL either commit the store to word addr[log2(DEPTH)+1:2] or register the load word; it SHALL then go to RESP.
REQ-020 resp_valid SHALL rise WAIT_CYCLES+1 edges after the accept edge; with default parameters, an accept at edge 0 gives resp_valid from edge 3.
REQ-021 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_valid && resp_ready on an edge, then the FSM SHALL go to IDLE.
REQ-022 Back-to-back operation: req_ready SHALL be 0 in the cycle resp completes; the minimum request period is WAIT_CYCLES+3 cycles.
REQ-023 Outside RESP, resp_valid and resp_err SHALL be 0 and resp_rdata SHALL be 0.
REQ-024 resp_err SHALL be 0 unless MEM_ERR_CHECK_EN is defined (REQ-028).

Reset
REQ-025 A reset at any edge, including mid-transaction, SHALL force IDLE, counter = 0, resp_valid = 0, resp_err = 0 and resp_rdata = 0.
REQ-026 A store whose ACCESS edge coincides with reset SHALL NOT be committed; a store already committed SHALL remain.
REQ-027 Memory contents SHALL NOT be cleared by reset; the array SHALL be zero at time 0.

Configuration
REQ-028 When MEM_ERR_CHECK_EN is defined, SHALL set resp_err = 1 in RESP if addr[1:0] != 0 or addr >= 4*DEPTH; a faulting store SHALL NOT write, and a faulting load SHALL return resp_rdata = 0.
REQ-029 When MEM_ERR_CHECK_EN is undefined, addr[1:0] and the bits above the index SHALL be ignored (the index wraps modulo DEPTH), and resp_err SHALL be tied to 0.

Structure
REQ-030 Package mem_pkg SHALL hold WORD_W = 32, the FSM state encoding (IDLE=0, WAIT=1, ACCESS=2, RESP=3) and the wait-counter width of 4.
REQ-031 The storage SHALL be a sub-module mem_array: single-port synchronous RAM with 32-bit data, one write enable and registered read.
REQ-032 The FSM, counter and error check SHALL reside in data_mem_responder.

Verification
REQ-033 Reset, then store addr=0x8, wdata=0xDEADBEEF, then load 0x8 -> resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid 3 edges after each accept.
REQ-034 Hold resp_ready = 0 for 5 cycles during a load response -> resp_valid and resp_rdata stay stable, req_ready stays 0, and a pending req_valid is not accepted.
REQ-035 WAIT_CYCLES = 0: load accepted at edge 0 -> resp_valid from edge 1.
REQ-036 Assert reset during WAIT of a store to 0x10 -> FSM returns to IDLE and a later load of 0x10 returns 0.
REQ-037 With MEM_ERR_CHECK_EN, store to 0x6 -> resp_err = 1 and word 1 is unchanged; load of 0x400 (DEPTH = 256) -> resp_err = 1, rdata = 0.
REQ-038 Without MEM_ERR_CHECK_EN, store 0x12345678 to 0x400, then load 0x0 -> 0x12345678, resp_err = 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: word width,
// FSM state encoding and wait-counter width.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: one write enable, registered read port.
// Contents start at zero and are never cleared afterwards.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] addr,
  input  word_t            wdata,
  output word_t            rdata
);

  // NOTE: storage has no reset branch; a reset port on a RAM prevents
  // block-RAM mapping and the contents must survive reset anyway.
  word_t mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data-memory responder with WAIT_CYCLES wait states per access.
// Define MEM_ERR_CHECK_EN to flag misaligned/out-of-range accesses via resp_err.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  req_valid,
  output logic  req_ready,
  input  logic  req_write,
  input  word_t req_addr,
  input  word_t req_wdata,
  output logic  resp_valid,
  input  logic  resp_ready,
  output word_t resp_rdata,
  output logic  resp_err
);

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam int              LOAD_I   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_I);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             write_q;
  word_t            addr_q;
  word_t            wdata_q;
  logic             accept;
  logic             fault;
  logic             ram_we;
  logic             ram_re;
  word_t            ram_rdata;

  assign accept = (state_q == IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      WAIT:    if (cnt_q == '0) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt_q   <= CNT_LOAD;
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef MEM_ERR_CHECK_EN
  assign fault    = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(4 * DEPTH));
  assign resp_err = (state_q == RESP) && fault;
`else
  // Byte offset and bits above the index are don't-care: the index wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[WORD_W-1:IDX_W+2], addr_q[1:0]};
  assign fault            = 1'b0;
  assign resp_err         = 1'b0;
`endif

  // Reset on the ACCESS edge suppresses the commit.
  assign ram_we = (state_q == ACCESS) && write_q && !fault && !reset;
  assign ram_re = (state_q == ACCESS) && !write_q && !fault;

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = ((state_q == RESP) && !write_q && !fault) ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// directed literal cases plus randomized traffic; a second WAIT_CYCLES=0 instance.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  word_t req_addr = '0, req_wdata = '0;
  logic  req_ready, resp_valid, resp_err;
  word_t resp_rdata;

  logic  reset_z = 1'b1;
  logic  req_valid_z = 1'b0, req_write_z = 1'b0, resp_ready_z = 1'b0;
  word_t req_addr_z = '0, req_wdata_z = '0;
  logic  req_ready_z, resp_valid_z, resp_err_z;
  word_t resp_rdata_z;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset_z),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z),
    .resp_rdata(resp_rdata_z), .resp_err(resp_err_z)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  word_t m_mem [DEPTH];
  bit    m_busy = 1'b0;
  bit    chk_en = 1'b0;
  int    m_age  = 0;
  bit    m_w    = 1'b0;
  word_t m_a = '0, m_d = '0, m_rd = '0;

  function automatic bit m_fault(input word_t a);
`ifdef MEM_ERR_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic int m_idx(input word_t a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Age counts edges since accept; the access happens on the edge that
  // brings the age to W+1, and the response is shown from then on.
  task automatic model_step();
    if (reset) begin
      m_busy = 1'b0;
      m_age  = 0;
      chk_en = 1'b1;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1'b1; m_age = 0;
        m_w = req_write; m_a = req_addr; m_d = req_wdata;
      end
    end else if (m_age >= W + 1) begin
      if (resp_ready) m_busy = 1'b0;
    end else begin
      m_age++;
      if (m_age == W + 1) begin
        if (m_fault(m_a)) m_rd = '0;
        else if (m_w) begin m_mem[m_idx(m_a)] = m_d; m_rd = '0; end
        else m_rd = m_mem[m_idx(m_a)];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_v = m_busy && (m_age >= W + 1);
        check("req_ready",  req_ready,  !m_busy);
        check("resp_valid", resp_valid, exp_v);
        check("resp_rdata", resp_rdata, exp_v ? m_rd : 32'h0);
        check("resp_err",   resp_err,   exp_v && m_fault(m_a));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic txn(input logic w, input word_t a, input word_t d, input int stall,
                     input bit pend, output word_t rd, output logic er, output int lat);
    int n;
    rd = '0; er = 1'b0; lat = 0;
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    if (!req_ready) begin check("accept_timeout", req_ready, 1); req_valid = 1'b0; return; end
    @(posedge clk); #2;
    // Scramble inputs after accept: the DUT must ignore them.
    req_valid = pend; req_write = 1'($urandom_range(0, 1));
    req_addr = $urandom; req_wdata = $urandom;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!resp_valid && lat < 50);
    if (!resp_valid) begin check("resp_timeout", resp_valid, 1); req_valid = 1'b0; return; end
    rd = resp_rdata; er = resp_err;
    repeat (stall) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #2;
    resp_ready = 1'b0; req_valid = 1'b0;
  endtask

  // Store accepted, then reset applied on the k-th edge after the accept edge.
  task automatic store_with_reset(input word_t a, input word_t d, input int k);
    @(posedge clk); #2;
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; resp_ready = 1'b1;
    @(negedge clk);
    check("rst_seq_ready", req_ready, 1);
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (k - 1) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    check("after_reset_ready", req_ready, 1);
    check("after_reset_valid", resp_valid, 0);
    check("after_reset_rdata", resp_rdata, 0);
  endtask

  initial begin
    word_t rd;
    logic  er;
    int    lat;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0; reset_z = 1'b0;
    @(negedge clk);
    check("reset_req_ready",  req_ready,  1);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_resp_rdata", resp_rdata, 0);
    check("reset_resp_err",   resp_err,   0);

    txn(1'b1, 32'h8, 32'hDEAD_BEEF, 0, 1'b0, rd, er, lat);
    check("store_latency", lat, 3);
    check("store_rdata", rd, 0);
    check("store_err", er, 0);
    txn(1'b0, 32'h8, 32'h0, 0, 1'b0, rd, er, lat);
    check("load_latency", lat, 3);
    check("load_rdata", rd, 32'hDEAD_BEEF);
    check("load_err", er, 0);

    // Five-cycle response stall with a new request pending.
    txn(1'b0, 32'h8, 32'h0, 5, 1'b1, rd, er, lat);
    check("stall_rdata", rd, 32'hDEAD_BEEF);
    check("stall_latency", lat, 3);

    store_with_reset(32'h10, 32'hCAFE_F00D, 1);   // reset in WAIT
    store_with_reset(32'h14, 32'h1111_2222, 3);   // reset on the ACCESS edge
    store_with_reset(32'h18, 32'h3333_4444, 4);   // reset after commit
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
    check("reset_wait_load", rd, 32'h0);
    txn(1'b0, 32'h14, 32'h0, 0, 1'b0, rd, er, lat);
    check("reset_access_load", rd, 32'h0);
    txn(1'b0, 32'h18, 32'h0, 0, 1'b0, rd, er, lat);
    check("reset_after_commit_load", rd, 32'h3333_4444);

`ifdef MEM_ERR_CHECK_EN
    txn(1'b1, 32'h6, 32'h5555_AAAA, 0, 1'b0, rd, er, lat);
    check("misaligned_store_err", er, 1);
    txn(1'b0, 32'h4, 32'h0, 0, 1'b0, rd, er, lat);
    check("word1_unchanged", rd, 32'h0);
    check("word1_err", er, 0);
    txn(1'b0, 32'h400, 32'h0, 0, 1'b0, rd, er, lat);
    check("oob_load_err", er, 1);
    check("oob_load_rdata", rd, 32'h0);
`else
    txn(1'b1, 32'h400, 32'h1234_5678, 0, 1'b0, rd, er, lat);
    check("wrap_store_err", er, 0);
    txn(1'b0, 32'h0, 32'h0, 0, 1'b0, rd, er, lat);
    check("wrap_load_rdata", rd, 32'h1234_5678);
    check("wrap_load_err", er, 0);
`endif

    for (int i = 0; i < 300; i++) begin
      word_t a;
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, 63));
        default: a = 32'($urandom_range(0, 15)) << 2;
      endcase
      txn(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), rd, er, lat);
      check("rand_latency", lat, W + 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Zero-wait instance: accept at edge 0 gives resp_valid from edge 1.
    @(posedge clk); #2;
    req_valid_z = 1'b1; req_write_z = 1'b1; req_addr_z = 32'h4;
    req_wdata_z = 32'hA5A5_0001; resp_ready_z = 1'b1;
    @(negedge clk);
    check("z_idle_ready", req_ready_z, 1);
    @(posedge clk); #2;
    req_valid_z = 1'b0;
    @(negedge clk);
    check("z_access_valid", resp_valid_z, 0);
    check("z_access_ready", req_ready_z, 0);
    @(negedge clk);
    check("z_store_valid_edge1", resp_valid_z, 1);
    check("z_store_rdata", resp_rdata_z, 0);
    @(posedge clk); #2;
    req_valid_z = 1'b1; req_write_z = 1'b0; req_addr_z = 32'h4;
    @(negedge clk);
    check("z_ready_after_resp", req_ready_z, 1);
    @(posedge clk); #2;
    req_valid_z = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("z_load_valid_edge1", resp_valid_z, 1);
    check("z_load_rdata", resp_rdata_z, 32'hA5A5_0001);
    check("z_load_err", resp_err_z, 0);
    @(posedge clk); #2;
    resp_ready_z = 1'b0;
    @(negedge clk);
    check("z_back_idle", req_ready_z, 1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
